data_mem_responder: RTL

Memory-side responder for the single-cycle processor's data port. It holds the image-word RAM that the processor reads and writes through `address`, `writeData`, `WR` and `readData`. It also owns the host path used to stream an encrypted image in before the run and to stream the decrypted result out afterwards. A three-state FSM (LOAD → RUN → DUMP) gates the processor's access so that host traffic and processor traffic never collide.

---
 rtl/data_mem_responder_if.sv | 32 +++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Bus bundle between the data-memory responder, the processor data port and the host stream.
// The processor/host side uses the master modport; the responder uses the slave modport.
interface data_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              WR;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              proc_en;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_ready;
    logic              dump_req;
    logic              dump_valid;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;
    logic              dump_ready;
    logic [15:0]       wr_count;

    modport master (
        output WR, address, writeData, ld_valid, ld_data, ld_last, dump_req, dump_ready,
        input  readData, proc_en, ld_ready, dump_valid, dump_data, dump_last, wr_count
    );

    modport slave (
        input  WR, address, writeData, ld_valid, ld_data, ld_last, dump_req, dump_ready,
        output readData, proc_en, ld_ready, dump_valid, dump_data, dump_last, wr_count
    );
endinterface

// File: rtl/data_mem_responder.sv
// Image-word RAM for the processor data port, sequenced LOAD -> RUN -> DUMP for host streaming.
// Define DMEM_WR_COUNT_EN to build the saturating processor-write counter; otherwise wr_count is 0.
module data_mem_responder #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    data_mem_responder_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_ldPtr;
    logic [ADDR_W-1:0] r_dumpPtr;
    logic              r_dumpValid;
    logic              r_dumpLast;
    logic [DATA_W-1:0] r_dumpData;
    logic              w_ldAccept;
    logic              w_ldDone;
    logic              w_procWrite;
    logic              w_dumpDone;
    logic              w_dumpLoad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_ldAccept  = 1'b0;
        w_ldDone    = 1'b0;
        w_procWrite = 1'b0;
        w_dumpDone  = 1'b0;
        w_dumpLoad  = 1'b0;
        unique case (r_state)
            LOAD: begin
                w_ldAccept = bus.ld_valid;
                w_ldDone   = bus.ld_valid && (bus.ld_last || (r_ldPtr == LAST_ADDR));
                if (w_ldDone) w_nextState = RUN;
            end
            RUN: begin
                w_procWrite = bus.WR;
                if (bus.dump_req) w_nextState = DUMP;
            end
            DUMP: begin
                w_dumpDone = r_dumpValid && bus.dump_ready && r_dumpLast;
                // Fetch the next word when the output slot is empty or being drained.
                w_dumpLoad = !w_dumpDone && (!r_dumpValid || bus.dump_ready);
                if (w_dumpDone) w_nextState = LOAD;
            end
            default: w_nextState = LOAD;
        endcase
    end

    // Host and processor writes are exclusive by state, so one write port suffices.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_ldAccept) begin
                r_mem[r_ldPtr] <= bus.ld_data;
            end else if (w_procWrite) begin
                r_mem[bus.address] <= bus.writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ldPtr     <= '0;
            r_dumpPtr   <= '0;
            r_dumpValid <= 1'b0;
            r_dumpLast  <= 1'b0;
            r_dumpData  <= '0;
        end else begin
            if (w_ldAccept && (r_ldPtr != LAST_ADDR)) begin
                r_ldPtr <= r_ldPtr + 1'b1;
            end
            if (w_dumpDone) begin
                r_ldPtr     <= '0;
                r_dumpPtr   <= '0;
                r_dumpValid <= 1'b0;
                r_dumpLast  <= 1'b0;
                r_dumpData  <= '0;
            end else if (w_dumpLoad) begin
                r_dumpData  <= r_mem[r_dumpPtr];
                r_dumpValid <= 1'b1;
                r_dumpLast  <= (r_dumpPtr == LAST_ADDR);
                r_dumpPtr   <= r_dumpPtr + 1'b1;
            end
        end
    end

`ifdef DMEM_WR_COUNT_EN
    logic [15:0] r_wrCount;

    always_ff @(posedge clk) begin
        if (rst || w_dumpDone) begin
            r_wrCount <= 16'h0000;
        end else if (w_procWrite && (r_wrCount != 16'hFFFF)) begin
            r_wrCount <= r_wrCount + 16'h0001;
        end
    end

    assign bus.wr_count = r_wrCount;
`else
    assign bus.wr_count = 16'h0000;
`endif

    assign bus.proc_en    = (r_state == RUN);
    assign bus.ld_ready   = (r_state == LOAD);
    assign bus.readData   = (r_state == RUN) ? r_mem[bus.address] : '0;
    assign bus.dump_valid = r_dumpValid;
    assign bus.dump_last  = r_dumpLast;
    assign bus.dump_data  = r_dumpData;
endmodule
